// File: rtl/sim_status_pkg.sv
// Shared status codes, channel state encoding and helpers for the SW test-status monitor.
package sim_status_pkg;

  localparam logic [15:0] CODE_BOOT    = 16'hB090;
  localparam logic [15:0] CODE_IN_TEST = 16'h4354;
  localparam logic [15:0] CODE_PASSED  = 16'h900D;
  localparam logic [15:0] CODE_FAILED  = 16'hBAAD;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BOOT    = 3'd1,
    ST_IN_TEST = 3'd2,
    ST_PASSED  = 3'd3,
    ST_FAILED  = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  function automatic logic is_terminal(input state_e s);
    return (s == ST_PASSED) || (s == ST_FAILED) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sim_status_chan.sv
// One monitored channel: window decode, status FSM, inactivity watchdog and optional hit history.
// History storage is present only when SIM_STATUS_HISTORY_EN is defined.
module sim_status_chan
  import sim_status_pkg::*;
#(
  parameter int AddrW     = 32,
  parameter int CntW      = 24,
  parameter int HistDepth = 4,
  parameter int IdxW      = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] win_addr_i,
  input  logic             wr_valid_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [15:0]      wr_data_i,
  input  logic [CntW-1:0]  timeout_cycles_i,
  input  logic [IdxW-1:0]  hist_idx_i,
  output state_e           state_o,
  output logic             unknown_o,
  output logic [15:0]      hist_data_o
);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            hit, active, expire;

  assign hit    = wr_valid_i && (wr_addr_i == win_addr_i);
  assign active = (state_q == ST_BOOT) || (state_q == ST_IN_TEST);
  assign expire = active && (timeout_cycles_i != '0) &&
                  (cnt_q == timeout_cycles_i - CntW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A hit on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    unknown_o = 1'b0;
    if (!is_terminal(state_q)) begin
      if (hit) begin
        case (wr_data_i)
          CODE_BOOT:    state_d = (state_q == ST_IN_TEST) ? ST_FAILED : ST_BOOT;
          CODE_IN_TEST: state_d = ST_IN_TEST;
          CODE_PASSED:  state_d = ST_PASSED;
          CODE_FAILED:  state_d = ST_FAILED;
          default:      unknown_o = 1'b1;
        endcase
      end else if (expire) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // Counter saturates at the limit (or all-ones when disabled) so it never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 cnt_q <= '0;
    else if (hit || !active)     cnt_q <= '0;
    else if (cnt_q != '1 && (timeout_cycles_i == '0 || cnt_q < timeout_cycles_i))
                                 cnt_q <= cnt_q + CntW'(1);
  end

  assign state_o = state_q;

`ifdef SIM_STATUS_HISTORY_EN
  logic [HistDepth-1:0][15:0] hist_q;

  // Entry 0 is the newest; every hit shifts, terminal or not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
    end else if (hit) begin
      for (int i = HistDepth - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
      hist_q[0] <= wr_data_i;
    end
  end

  assign hist_data_o = hist_q[hist_idx_i];
`else
  logic unused_hist;
  assign unused_hist = ^hist_idx_i;
  assign hist_data_o = 16'h0;
`endif

endmodule

// File: rtl/sim_status_monitor.sv
// Multi-channel SW test-status monitor: NumCh channel instances plus done/passed/unknown aggregation.
// Optional per-channel history read port enabled by SIM_STATUS_HISTORY_EN.
module sim_status_monitor
  import sim_status_pkg::*;
#(
  parameter int  NumCh     = 2,
  parameter int  AddrW     = 32,
  parameter int  CntW      = 24,
  parameter int  HistDepth = 4,
  localparam int HistIdxW  = (HistDepth > 1) ? $clog2(HistDepth) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [AddrW-1:0]            start_addr_i,
  input  logic [NumCh-1:0]            wr_valid_i,
  input  logic [NumCh-1:0][AddrW-1:0] wr_addr_i,
  input  logic [NumCh-1:0][15:0]      wr_data_i,
  input  logic [CntW-1:0]             timeout_cycles_i,
  output logic [NumCh-1:0][2:0]       ch_state_o,
  output logic [NumCh-1:0]            pass_mask_o,
  output logic [NumCh-1:0]            fail_mask_o,
  output logic [NumCh-1:0]            timeout_mask_o,
  output logic                        done_o,
  output logic                        passed_o,
  output logic [7:0]                  unknown_cnt_o,
  input  logic [2:0]                  hist_ch_i,
  input  logic [HistIdxW-1:0]         hist_idx_i,
  output logic [15:0]                 hist_data_o
);

  state_e                   chan_state [NumCh];
  logic [NumCh-1:0]         chan_unk;
  logic [NumCh-1:0][15:0]   chan_hist;
  logic [NumCh-1:0]         chan_term;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    sim_status_chan #(
      .AddrW     (AddrW),
      .CntW      (CntW),
      .HistDepth (HistDepth),
      .IdxW      (HistIdxW)
    ) u_chan (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .win_addr_i       (start_addr_i + AddrW'(4 * c)),
      .wr_valid_i       (wr_valid_i[c]),
      .wr_addr_i        (wr_addr_i[c]),
      .wr_data_i        (wr_data_i[c]),
      .timeout_cycles_i (timeout_cycles_i),
      .hist_idx_i       (hist_idx_i),
      .state_o          (chan_state[c]),
      .unknown_o        (chan_unk[c]),
      .hist_data_o      (chan_hist[c])
    );

    assign ch_state_o[c]     = chan_state[c];
    assign pass_mask_o[c]    = (chan_state[c] == ST_PASSED);
    assign fail_mask_o[c]    = (chan_state[c] == ST_FAILED);
    assign timeout_mask_o[c] = (chan_state[c] == ST_TIMEOUT);
    assign chan_term[c]      = is_terminal(chan_state[c]);
  end

  logic [3:0] unk_inc;
  logic [8:0] unk_sum;
  logic [7:0] unk_q;
  logic       done_q;

  always_comb begin
    unk_inc = '0;
    for (int c = 0; c < NumCh; c++) unk_inc = unk_inc + 4'(chan_unk[c]);
  end

  assign unk_sum = {1'b0, unk_q} + 9'(unk_inc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unk_q  <= '0;
      done_q <= 1'b0;
    end else begin
      unk_q  <= unk_sum[8] ? 8'hFF : unk_sum[7:0];
      done_q <= done_q | (&chan_term);
    end
  end

  assign unknown_cnt_o = unk_q;
  assign done_o        = done_q;
  assign passed_o      = done_q & (&pass_mask_o);

  // Out-of-range channel selects read back as zero.
  always_comb begin
    hist_data_o = 16'h0;
    for (int c = 0; c < NumCh; c++)
      if (hist_ch_i == 3'(c)) hist_data_o = chan_hist[c];
  end

endmodule
